// File: rtl/riscv_alu_if.sv
// Operand/result bundle between the RV32I datapath and its ALU.
// master drives the operation, slave (the ALU) returns the registered result and flags.
interface riscv_alu_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             negative;

  modport master (
    output alu_sel, bus_a, bus_b,
    input  alu_out, zero, negative
  );

  modport slave (
    input  alu_sel, bus_a, bus_b,
    output alu_out, zero, negative
  );
endinterface

// File: rtl/riscv_alu.sv
// 32-bit RV32I ALU with a registered result and zero/negative flags (1-cycle latency).
// Define ALU_MUL_EN to add MUL (sel 12) and MULH (sel 13); otherwise sel 12-15 return 0.
module riscv_alu #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  riscv_alu_if.slave  alu_bus
);

  localparam logic [SEL_W-1:0] OP_ADD    = 4'd0;
  localparam logic [SEL_W-1:0] OP_SUB    = 4'd1;
  localparam logic [SEL_W-1:0] OP_SLL    = 4'd2;
  localparam logic [SEL_W-1:0] OP_SRL    = 4'd3;
  localparam logic [SEL_W-1:0] OP_SRA    = 4'd4;
  localparam logic [SEL_W-1:0] OP_AND    = 4'd5;
  localparam logic [SEL_W-1:0] OP_OR     = 4'd6;
  localparam logic [SEL_W-1:0] OP_XOR    = 4'd7;
  localparam logic [SEL_W-1:0] OP_SLT    = 4'd8;
  localparam logic [SEL_W-1:0] OP_SLTU   = 4'd9;
  localparam logic [SEL_W-1:0] OP_PASS_A = 4'd10;
  localparam logic [SEL_W-1:0] OP_PASS_B = 4'd11;
`ifdef ALU_MUL_EN
  localparam logic [SEL_W-1:0] OP_MUL    = 4'd12;
  localparam logic [SEL_W-1:0] OP_MULH   = 4'd13;
`endif

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             negative_q;

  assign a     = alu_bus.bus_a;
  assign b     = alu_bus.bus_b;
  // RV32I shifts use only the low five bits; a shift by 32 wraps to 0.
  assign shamt = b[4:0];

`ifdef ALU_MUL_EN
  // Sign-extending both operands to 64 bits makes the unsigned product equal the signed one.
  logic [2*WIDTH-1:0] product;
  assign product = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives result and no latch is inferred.
    result = '0;
    case (alu_bus.alu_sel)
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_SLL:    result = a << shamt;
      OP_SRL:    result = a >> shamt;
      OP_SRA:    result = $signed(a) >>> shamt;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_SLT:    result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:   result = {{(WIDTH-1){1'b0}}, a < b};
      OP_PASS_A: result = a;
      OP_PASS_B: result = b;
`ifdef ALU_MUL_EN
      OP_MUL:    result = product[WIDTH-1:0];
      OP_MULH:   result = product[2*WIDTH-1:WIDTH];
`endif
      default:   result = '0;
    endcase
  end

  // Flags derive from the same value that is registered, so they never disagree with alu_out.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update together on the edge.
    if (reset) begin
      out_q      <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
    end else begin
      out_q      <= result;
      zero_q     <= (result == '0);
      negative_q <= result[WIDTH-1];
    end
  end

  assign alu_bus.alu_out  = out_q;
  assign alu_bus.zero     = zero_q;
  assign alu_bus.negative = negative_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu: the driver queues hand-computed results,
// an independent monitor pops and compares them one cycle after each issue.
module tb_riscv_alu;

  typedef struct packed {
    logic [31:0] out;
    logic        zero;
    logic        negative;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  riscv_alu_if #(.WIDTH(32), .SEL_W(4)) alu_bus ();

  riscv_alu #(.WIDTH(32), .SEL_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .alu_bus (alu_bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One operation per cycle: drive on the falling edge, expect it after the next rising edge.
  task automatic issue(input string name, input logic rst, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_out);
    exp_t e;
    @(negedge clk);
    reset           = rst;
    alu_bus.alu_sel = sel;
    alu_bus.bus_a   = a;
    alu_bus.bus_b   = b;
    e.out      = exp_out;
    e.zero     = (exp_out == 32'h0);
    e.negative = exp_out[31];
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  always begin : monitor
    exp_t  e;
    string n;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".out"},      alu_bus.alu_out,         e.out);
      check({n, ".zero"},     {31'b0, alu_bus.zero},     {31'b0, e.zero});
      check({n, ".negative"}, {31'b0, alu_bus.negative}, {31'b0, e.negative});
    end
  end

  initial begin
    alu_bus.alu_sel = 4'd0;
    alu_bus.bus_a   = 32'd0;
    alu_bus.bus_b   = 32'd0;

    issue("reset0",     1'b1, 4'd0,  32'd5,         32'd3,  32'h0);
    issue("reset1",     1'b1, 4'd0,  32'd5,         32'd3,  32'h0);
    issue("release",    1'b0, 4'd0,  32'd5,         32'd3,  32'd8);

    issue("add",        1'b0, 4'd0,  32'd1000,      32'd7,  32'd1007);
    issue("sub",        1'b0, 4'd1,  32'd1000,      32'd7,  32'd993);
    issue("sub_neg",    1'b0, 4'd1,  32'd3,         32'd5,  32'hFFFF_FFFE);
    issue("add_wrap",   1'b0, 4'd0,  32'h7FFF_FFFF, 32'd1,  32'h8000_0000);
    issue("add_ovf0",   1'b0, 4'd0,  32'hFFFF_FFFF, 32'd1,  32'h0);

    issue("sll",        1'b0, 4'd2,  32'h8000_0010, 32'd4,  32'h0000_0100);
    issue("srl",        1'b0, 4'd3,  32'h8000_0010, 32'd4,  32'h0800_0001);
    issue("sra",        1'b0, 4'd4,  32'h8000_0010, 32'd4,  32'hF800_0001);
    issue("sll_b33",    1'b0, 4'd2,  32'd1,         32'd33, 32'd2);
    issue("sra_b32",    1'b0, 4'd4,  32'h8000_1234, 32'd32, 32'h8000_1234);
    issue("sra_31",     1'b0, 4'd4,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF);

    issue("and",        1'b0, 4'd5,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
    issue("or",         1'b0, 4'd6,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0);
    issue("xor",        1'b0, 4'd7,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
    issue("xor_zero",   1'b0, 4'd7,  32'd5,         32'd5,  32'h0);

    issue("slt_m1",     1'b0, 4'd8,  32'hFFFF_FFFF, 32'd1,  32'd1);
    issue("sltu_m1",    1'b0, 4'd9,  32'hFFFF_FFFF, 32'd1,  32'd0);
    issue("slt_eq",     1'b0, 4'd8,  32'd7,         32'd7,  32'd0);
    issue("sltu_eq",    1'b0, 4'd9,  32'd7,         32'd7,  32'd0);

    issue("pass_a",     1'b0, 4'd10, 32'd123,       32'd55, 32'd123);
    issue("pass_b",     1'b0, 4'd11, 32'd77,        32'd9,  32'd9);
    issue("sel15",      1'b0, 4'd15, 32'd123,       32'd9,  32'h0);
    issue("sel14",      1'b0, 4'd14, 32'd123,       32'd9,  32'h0);
`ifdef ALU_MUL_EN
    issue("mul",        1'b0, 4'd12, 32'd6,         32'd7,  32'd42);
    issue("mulh",       1'b0, 4'd13, 32'hFFFF_FFFE, 32'd3,  32'hFFFF_FFFF);
`else
    issue("sel12",      1'b0, 4'd12, 32'd6,         32'd7,  32'h0);
    issue("sel13",      1'b0, 4'd13, 32'hFFFF_FFFE, 32'd3,  32'h0);
`endif

    issue("b2b_add",    1'b0, 4'd0,  32'd10,        32'd20, 32'd30);
    issue("b2b_sub",    1'b0, 4'd1,  32'd10,        32'd20, 32'hFFFF_FFF6);
    issue("b2b_and",    1'b0, 4'd5,  32'h0000_00FF, 32'h0000_0F0F, 32'h0000_000F);
    issue("reset_mid",  1'b1, 4'd0,  32'h8000_0000, 32'd5,  32'h0);
    issue("after_rst",  1'b0, 4'd11, 32'd0,         32'h8000_0001, 32'h8000_0001);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
